// File: rtl/piso_serializer.sv
// Parallel-in/serial-out framer feeding the downstream 4-bit shift stage.
// Define SER_PARITY_EN to append an even-parity bit (adds the PAR state).
module piso_serializer #(
  parameter int DATA_W    = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              x_o,
  output logic              x_valid_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DATA_W);

  // state | meaning
  // IDLE  | no frame in flight
  // SHIFT | data bits are on x_o
  // PAR   | parity bit is on x_o (SER_PARITY_EN only)
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state;
  logic [DATA_W-2:0] shreg;
  logic [CW-1:0]     cnt;
`ifdef SER_PARITY_EN
  logic              par;
`endif

  logic              last_bit;
  logic              accept;
  logic              first_bit;
  logic [DATA_W-2:0] rest_bits;
  logic              next_bit;
  logic [DATA_W-2:0] shreg_shifted;

`ifdef SER_PARITY_EN
  assign last_bit = (state == PAR);
`else
  assign last_bit = (state == SHIFT) && (cnt == '0);
`endif

  assign ready_o = (state == IDLE) || last_bit;
  assign accept  = valid_i && ready_o;
  assign busy_o  = (state != IDLE);

  // Bit order is fixed at elaboration; the shift register always holds the
  // bits still to be sent with the next one at the output end.
  assign first_bit     = LSB_FIRST ? data_i[0] : data_i[DATA_W-1];
  assign rest_bits     = LSB_FIRST ? data_i[DATA_W-1:1] : data_i[DATA_W-2:0];
  assign next_bit      = LSB_FIRST ? shreg[0] : shreg[DATA_W-2];
  assign shreg_shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      x_o          <= 1'b0;
      x_valid_o    <= 1'b0;
      frame_done_o <= 1'b0;
      shreg        <= '0;
      cnt          <= '0;
`ifdef SER_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      if (accept) begin
        // Also taken on the last-bit edge, so frames stream without a bubble.
        state        <= SHIFT;
        x_o          <= first_bit;
        x_valid_o    <= 1'b1;
        frame_done_o <= 1'b0;
        shreg        <= rest_bits;
        cnt          <= CW'(DATA_W - 1);
`ifdef SER_PARITY_EN
        par          <= ^data_i;
`endif
      end else if (last_bit) begin
        state        <= IDLE;
        x_o          <= 1'b0;
        x_valid_o    <= 1'b0;
        frame_done_o <= 1'b0;
      end else if (state == SHIFT) begin
        if (cnt != '0) begin
          x_o   <= next_bit;
          shreg <= shreg_shifted;
          cnt   <= cnt - CW'(1);
`ifdef SER_PARITY_EN
          frame_done_o <= 1'b0;
`else
          frame_done_o <= (cnt == CW'(1));
`endif
        end
`ifdef SER_PARITY_EN
        else begin
          state        <= PAR;
          x_o          <= par;
          frame_done_o <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first instance plus an LSB-first one.
// Expected frames follow SER_PARITY_EN when it is defined for the build.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
  localparam int L = 5;
  localparam logic [15:0] E_1011 = 16'b10111;
  localparam logic [15:0] E_0110 = 16'b01100;
  localparam logic [15:0] E_A5   = 16'b1010001010;
  localparam logic [15:0] E_BP   = 16'b0011011000;
  localparam logic [15:0] E_LSB  = 16'b10001;
  localparam logic [15:0] E_9    = 16'b10010;
`else
  localparam int L = 4;
  localparam logic [15:0] E_1011 = 16'b1011;
  localparam logic [15:0] E_0110 = 16'b0110;
  localparam logic [15:0] E_A5   = 16'b10100101;
  localparam logic [15:0] E_BP   = 16'b00111100;
  localparam logic [15:0] E_LSB  = 16'b1000;
  localparam logic [15:0] E_9    = 16'b1001;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data;
  logic       valid;
  logic       ready, x, xv, fd, busy;
  logic [3:0] l_data;
  logic       l_valid;
  logic       l_ready, l_x, l_xv, l_fd, l_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(4), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .data_i(data), .valid_i(valid),
    .ready_o(ready), .x_o(x), .x_valid_o(xv), .frame_done_o(fd), .busy_o(busy)
  );

  piso_serializer #(.DATA_W(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .data_i(l_data), .valid_i(l_valid),
    .ready_o(l_ready), .x_o(l_x), .x_valid_o(l_xv), .frame_done_o(l_fd),
    .busy_o(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input string tag, input logic [3:0] d);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
  endtask

  // Checks n consecutive bits (first bit at exp[n-1]); optionally raises
  // valid with pend_d at index pend_at; drops valid before the final edge.
  task automatic expect_stream(input string tag, input logic [15:0] exp, input int n,
                               input int pend_at, input logic [3:0] pend_d);
    for (int i = 0; i < n; i++) begin
      logic last;
      last = ((i % L) == L - 1);
      if (i == pend_at) begin
        valid = 1'b1;
        data  = pend_d;
      end
      check($sformatf("%s_x%0d", tag, i),     32'(x),     32'(exp[n-1-i]));
      check($sformatf("%s_xv%0d", tag, i),    32'(xv),    32'd1);
      check($sformatf("%s_fd%0d", tag, i),    32'(fd),    32'(last));
      check($sformatf("%s_rdy%0d", tag, i),   32'(ready), 32'(last));
      check($sformatf("%s_busy%0d", tag, i),  32'(busy),  32'd1);
      if (i == n - 1) valid = 1'b0;
      tick();
    end
    check({tag, "_idle_xv"},   32'(xv),    32'd0);
    check({tag, "_idle_x"},    32'(x),     32'd0);
    check({tag, "_idle_busy"}, 32'(busy),  32'd0);
    check({tag, "_idle_rdy"},  32'(ready), 32'd1);
  endtask

  initial begin
    reset   = 1'b0;
    valid   = 1'b0;
    data    = 4'h0;
    l_valid = 1'b0;
    l_data  = 4'h0;
    #12;
    check("rst_x",    32'(x),     32'd0);
    check("rst_xv",   32'(xv),    32'd0);
    check("rst_fd",   32'(fd),    32'd0);
    check("rst_busy", 32'(busy),  32'd0);
    check("rst_rdy",  32'(ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    send_word("single", 4'b1011);
    expect_stream("single", E_1011, L, -1, 4'h0);

    send_word("w0110", 4'b0110);
    expect_stream("w0110", E_0110, L, -1, 4'h0);

    check("b2b_ready", 32'(ready), 32'd1);
    valid = 1'b1;
    data  = 4'hA;
    tick();
    data  = 4'h5;
    expect_stream("b2b", E_A5, 2 * L, -1, 4'h0);

    send_word("bp", 4'h3);
    expect_stream("bp", E_BP, 2 * L, 1, 4'hC);

    check("lsb_ready", 32'(l_ready), 32'd1);
    l_valid = 1'b1;
    l_data  = 4'b0001;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      check($sformatf("lsb_x%0d", i),  32'(l_x),  32'(E_LSB[L-1-i]));
      check($sformatf("lsb_xv%0d", i), 32'(l_xv), 32'd1);
      check($sformatf("lsb_fd%0d", i), 32'(l_fd), 32'(i == L - 1));
      tick();
    end
    check("lsb_idle_xv", 32'(l_xv), 32'd0);

    send_word("rstmid", 4'hF);
    check("rstmid_bit0", 32'(x), 32'd1);
    tick();
    check("rstmid_bit1", 32'(x), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_x",    32'(x),     32'd0);
    check("rstmid_xv",   32'(xv),    32'd0);
    check("rstmid_fd",   32'(fd),    32'd0);
    check("rstmid_busy", 32'(busy),  32'd0);
    check("rstmid_rdy",  32'(ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_xv", 32'(xv), 32'd0);
    send_word("w9", 4'h9);
    expect_stream("w9", E_9, L, -1, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out framer that sits directly upstream of the 4-bit serial shift register stage and drives that stage's serial input `x_i`. It accepts a parallel word over a valid/ready handshake and emits it one bit per clock. It can append an optional even-parity bit. Back-to-back words stream with no idle gap, so the downstream shift register sees a continuous bit stream.

## Interface
- `DATA_W`, default 4: word width in bits; legal range 2..32.
- `LSB_FIRST`, default 0: 0 sends MSB first; 1 sends LSB first.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is synchronous to `clk`.
- `data_i` input DATA_W: parallel word. Sampled only on an accept edge.
- `valid_i` input 1: upstream has a word on `data_i`.
- `ready_o` output 1: block can accept a word this cycle.
- `x_o` output 1: serial bit, registered. Connects to the shift register's `x_i`.
- `x_valid_o` output 1: `x_o` carries a frame bit this cycle, registered.
- `frame_done_o` output 1: registered; high for one cycle, coincident with the last bit of a frame on `x_o`.
- `busy_o` output 1: a frame is in flight (FSM not in IDLE).

## Operation
- FSM states:
  - IDLE: no frame in flight.
  - SHIFT: data bits are on `x_o`.
  - PAR: parity bit is on `x_o`; this state exists only with PARITY_EN.
- Accept rule: a word is accepted on a rising edge where `valid_i && ready_o`. No other edge samples `data_i`.
- On accept:
  - The first bit goes to `x_o`, and `x_valid_o` is set to 1.
  - The remaining DATA_W-1 bits are loaded into the internal shift register.
  - The bit counter is loaded with DATA_W-1.
  - The parity accumulator is loaded with XOR(`data_i`).
  - Next state is SHIFT.
- In SHIFT, each edge shifts the next bit to `x_o` and decrements the counter.
- Last-bit condition: the counter is 0 and the state is SHIFT (no parity), or the state is PAR.
- `ready_o` is combinational: `ready_o = (state==IDLE) || last-bit condition`. It never depends on `valid_i`.
- At the edge that ends the last bit:
  - If a word is accepted on that same edge, the new frame's first bit follows immediately, with `x_valid_o` held at 1 and no bubble.
  - Otherwise the FSM returns to IDLE, and `x_o` and `x_valid_o` go to 0.
- Bit-order counter width: `$clog2(DATA_W)` bits. The counter must not wrap below 0.
- `frame_done_o` is 1 exactly when `x_valid_o` is 1 and the last-bit condition holds.
- While `ready_o`=0, `valid_i` is held pending. Upstream must keep `data_i` stable; the block takes no action.
- Reset values: `x_o`=0, `x_valid_o`=0, `frame_done_o`=0, `busy_o`=0, state=IDLE. `ready_o` is therefore 1 during and after reset. The shift register, counter and parity accumulator are all 0.
- Reset mid-frame: the frame is discarded immediately and no remaining bits are emitted. The first edge after release is IDLE behaviour.

## Timing
- Accept at edge N: data bit k is on `x_o` during cycle N+1+k, for k=0..DATA_W-1.
- The parity bit, if enabled, is on `x_o` during cycle N+1+DATA_W.
- Frame length L = DATA_W, plus 1 with PARITY_EN. Latency from accept to first bit is 1 cycle.
- Sustained throughput is one word per L cycles when `valid_i` is held high.

## Configuration
- `SER_PARITY_EN` defined:
  - The PAR state is compiled in.
  - One even-parity bit is appended after the data bits. It equals the XOR of all data bits, so total ones per frame is even.
  - L = DATA_W+1.
- `SER_PARITY_EN` undefined:
  - There is no PAR state and no parity logic.
  - The last-bit condition is SHIFT with counter 0.
  - L = DATA_W.

## Test plan
All scenarios use DATA_W=4 and LSB_FIRST=0 unless stated otherwise.
- Single word, no parity: accept 4'b1011 at edge N. Expect `x_o`=1,0,1,1 in cycles N+1..N+4, with `x_valid_o`=1 throughout. Expect `frame_done_o`=1 only in N+4, then `x_valid_o`=0 in N+5.
- Back-to-back: hold `valid_i`=1 with 4'hA, then 4'h5 presented at the first `ready_o`. Expect 8 contiguous valid bits 1,0,1,0,0,1,0,1, and `ready_o`=1 only in cycles N+4 and N+8.
- Parity (`SER_PARITY_EN`): send 4'b1011 and expect the 5-bit frame 1,0,1,1,1. Send 4'b0110 and expect 0,1,1,0,0. `frame_done_o` is on the parity bit.
- LSB_FIRST=1: send 4'b0001 and expect `x_o`=1,0,0,0.
- Backpressure: assert `valid_i` with 4'hC during cycle N+2 of a frame. Expect no accept until the last-bit cycle. Then 4'hC streams gap-free.
- Reset mid-frame: drive `reset`=0 during the second bit of 4'hF. Expect `x_o`, `x_valid_o` and `busy_o` to be 0 immediately and `ready_o`=1. After release, a new word 4'h9 transmits normally as 1,0,0,1.
